// File: rtl/stack_mem_sequencer.sv
// Stack/load-store memory sequencer.
// Owns a single-port data memory on behalf of the return-address stack and
// the load/store path. Keeps the architectural SP, turns each push/pop into
// memory cycles, arbitrates between the two requesters and reports stack
// overflow/underflow.
module stack_mem_sequencer #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] STACK_BASE  = ADDR_W'(192),
    parameter int                STACK_DEPTH = 16,
    parameter int                MEM_LAT     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_req,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop_req,
    output logic              stk_ack,
    output logic [DATA_W-1:0] pop_data,
    output logic              stk_overflow,
    output logic              stk_underflow,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ack,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] sp,
    output logic              busy
);

    localparam int                CNT_W     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'(MEM_LAT - 1);
    localparam logic [ADDR_W-1:0] STACK_TOP = STACK_BASE + ADDR_W'(STACK_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        PUSH,
        POP,
        LSW,
        LSR,
        WAIT,
        ACK
    } state_t;

    state_t           state;
    logic             last_stk;   // last grant went to the stack; also tags the op in flight
    logic [CNT_W-1:0] wait_cnt;

    logic stk_full;
    logic stk_empty;
    logic grant_ls;

    assign stk_full  = (sp == STACK_TOP);
    assign stk_empty = (sp == STACK_BASE);
    // Load/store wins outright after a stack grant so it cannot be starved
    // by back-to-back calls/returns; otherwise it has lowest priority.
    assign grant_ls  = ls_req && (last_stk || (!pop_req && !push_req));
    assign busy      = (state != IDLE);

    // Sequencer FSM: arbitration, memory command generation, SP and result latching.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            sp            <= STACK_BASE;
            last_stk      <= 1'b0;
            wait_cnt      <= '0;
            stk_ack       <= 1'b0;
            stk_overflow  <= 1'b0;
            stk_underflow <= 1'b0;
            ls_ack        <= 1'b0;
            pop_data      <= '0;
            ls_rdata      <= '0;
            mem_en        <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
        end else begin
            // Pulses and memory command are single-cycle unless re-issued below.
            stk_ack       <= 1'b0;
            stk_overflow  <= 1'b0;
            stk_underflow <= 1'b0;
            ls_ack        <= 1'b0;
            mem_en        <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;

            case (state)
                IDLE: begin
                    if (grant_ls) begin
                        last_stk <= 1'b0;
                        mem_en   <= 1'b1;
                        mem_we   <= ls_we;
                        mem_addr <= ls_addr;
                        if (ls_we) begin
                            mem_wdata <= ls_wdata;
                            ls_ack    <= 1'b1;
                            state     <= LSW;
                        end else begin
                            state     <= LSR;
                        end
                    end else if (pop_req) begin
                        last_stk <= 1'b1;
                        state    <= POP;
                        if (stk_empty) begin
                            stk_ack       <= 1'b1;
                            stk_underflow <= 1'b1;
                        end else begin
                            mem_en   <= 1'b1;
                            mem_addr <= sp - ADDR_W'(1);
                        end
                    end else if (push_req) begin
                        last_stk <= 1'b1;
                        state    <= PUSH;
                        stk_ack  <= 1'b1;
                        if (stk_full) begin
                            stk_overflow <= 1'b1;
                        end else begin
                            mem_en    <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= sp;
                            mem_wdata <= push_data;
                        end
                    end
                end

                PUSH: begin
                    // SP is still the pre-push value here, so stk_full
                    // matches the decision taken at grant time.
                    if (!stk_full) begin
                        sp <= sp + ADDR_W'(1);
                    end
                    state <= IDLE;
                end

                POP: begin
                    if (stk_empty) begin
                        state <= IDLE;
                    end else begin
                        sp       <= sp - ADDR_W'(1);
                        wait_cnt <= WAIT_LOAD;
                        state    <= WAIT;
                    end
                end

                LSW: begin
                    state <= IDLE;
                end

                LSR: begin
                    wait_cnt <= WAIT_LOAD;
                    state    <= WAIT;
                end

                WAIT: begin
                    if (wait_cnt == '0) begin
                        if (last_stk) begin
                            pop_data <= mem_rdata;
                            stk_ack  <= 1'b1;
                        end else begin
                            ls_rdata <= mem_rdata;
                            ls_ack   <= 1'b1;
                        end
                        state <= ACK;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end

                ACK: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_mem_sequencer.sv
// Directed bench for stack_mem_sequencer: one instance with a 1-cycle memory
// for stack and arbitration traffic, one with a 3-cycle memory for a load.
module tb_stack_mem_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with MEM_LAT=1
    logic        reset, push_req, pop_req, stk_ack, stk_overflow, stk_underflow;
    logic        ls_req, ls_we, ls_ack, mem_en, mem_we, busy;
    logic [31:0] push_data, pop_data, ls_addr, ls_wdata, ls_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, sp;

    // Instance with MEM_LAT=3
    logic        reset3, push_req3, pop_req3, stk_ack3, stk_overflow3, stk_underflow3;
    logic        ls_req3, ls_we3, ls_ack3, mem_en3, mem_we3, busy3;
    logic [31:0] push_data3, pop_data3, ls_addr3, ls_wdata3, ls_rdata3;
    logic [31:0] mem_addr3, mem_wdata3, mem_rdata3, sp3;

    stack_mem_sequencer #(.MEM_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .push_req(push_req), .push_data(push_data), .pop_req(pop_req),
        .stk_ack(stk_ack), .pop_data(pop_data),
        .stk_overflow(stk_overflow), .stk_underflow(stk_underflow),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ack(ls_ack), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .sp(sp), .busy(busy)
    );

    stack_mem_sequencer #(.MEM_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset3),
        .push_req(push_req3), .push_data(push_data3), .pop_req(pop_req3),
        .stk_ack(stk_ack3), .pop_data(pop_data3),
        .stk_overflow(stk_overflow3), .stk_underflow(stk_underflow3),
        .ls_req(ls_req3), .ls_we(ls_we3), .ls_addr(ls_addr3), .ls_wdata(ls_wdata3),
        .ls_ack(ls_ack3), .ls_rdata(ls_rdata3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3),
        .sp(sp3), .busy(busy3)
    );

    // 1-cycle memory; returns a marker pattern when no read was issued
    logic [31:0] mem1 [0:255];
    always @(posedge clk) begin
        if (mem_en && mem_we) mem1[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= (mem_en && !mem_we) ? mem1[mem_addr[7:0]] : 32'hBAD0_BAD0;
    end

    // 3-cycle memory: 0xDEAD is visible only MEM_LAT cycles after a read of 0x40
    logic [2:0] rv3 = 3'b000;
    always @(posedge clk) rv3 <= {rv3[1:0], (mem_en3 && !mem_we3 && mem_addr3 == 32'h40)};
    assign mem_rdata3 = rv3[2] ? 32'h0000_DEAD : 32'h0;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_stk[$];
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [31:0] d);
        logic [31:0] sp0;
        logic        full;
        sp0  = 32'd192 + 32'(model_stk.size());
        full = (model_stk.size() == 16);
        push_req  = 1'b1;
        push_data = d;
        tick;
        push_req = 1'b0;
        check("push_ack", stk_ack, 1);
        check("push_ovf", stk_overflow, full);
        check("push_mem_en", mem_en, !full);
        if (!full) begin
            check("push_mem_we", mem_we, 1);
            check("push_mem_addr", mem_addr, sp0);
            check("push_mem_wdata", mem_wdata, d);
            model_stk.push_back(d);
        end
        tick;
        check("push_sp", sp, full ? sp0 : sp0 + 1);
        check("push_ack_low", stk_ack, 0);
        check("push_idle", busy, 0);
    endtask

    task automatic do_pop;
        logic [31:0] sp0;
        logic        empty;
        sp0   = 32'd192 + 32'(model_stk.size());
        empty = (model_stk.size() == 0);
        if (!empty) exp_q.push_back(model_stk.pop_back());
        pop_req = 1'b1;
        tick;
        pop_req = 1'b0;
        if (empty) begin
            check("pop_udf", stk_underflow, 1);
            check("pop_udf_ack", stk_ack, 1);
            check("pop_udf_mem_en", mem_en, 0);
            tick;
            check("pop_udf_sp", sp, sp0);
            check("pop_udf_idle", busy, 0);
        end else begin
            check("pop_mem_en", mem_en, 1);
            check("pop_mem_we", mem_we, 0);
            check("pop_mem_addr", mem_addr, sp0 - 1);
            check("pop_early_ack", stk_ack, 0);
            tick;
            check("pop_wait_ack", stk_ack, 0);
            check("pop_wait_mem_en", mem_en, 0);
            check("pop_sp", sp, sp0 - 1);
            tick;
            check("pop_ack", stk_ack, 1);
            check("pop_no_udf", stk_underflow, 0);
            check("pop_data", pop_data, exp_q.pop_front());
            tick;
            check("pop_ack_low", stk_ack, 0);
            check("pop_idle", busy, 0);
        end
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = a; ls_wdata = d;
        tick;
        ls_req = 1'b0;
        check("st_ack", ls_ack, 1);
        check("st_mem_en", mem_en, 1);
        check("st_mem_we", mem_we, 1);
        check("st_mem_addr", mem_addr, a);
        check("st_mem_wdata", mem_wdata, d);
        tick;
        check("st_ack_low", ls_ack, 0);
        check("st_idle", busy, 0);
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        tick;
        tick;
        check("rst_sp", sp, 192);
        check("rst_busy", busy, 0);
        check("rst_stk_ack", stk_ack, 0);
        check("rst_ls_ack", ls_ack, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_pop_data", pop_data, 0);
        check("rst_ls_rdata", ls_rdata, 0);
        reset = 1'b0;
        model_stk.delete();
        tick;
    endtask

    initial begin
        int pop_c, ls_c, push_c, nacks;
        reset = 1'b1; push_req = 0; pop_req = 0; ls_req = 0; ls_we = 0;
        push_data = 0; ls_addr = 0; ls_wdata = 0;
        reset3 = 1'b1; push_req3 = 0; pop_req3 = 0; ls_req3 = 0; ls_we3 = 0;
        push_data3 = 0; ls_addr3 = 0; ls_wdata3 = 0;
        #1;
        tick;
        reset3 = 1'b0;
        apply_reset;

        // Two pushes, two pops, then underflow
        do_push(32'h100);
        do_push(32'h104);
        check("sp_after_pushes", sp, 194);
        do_pop;
        do_pop;
        check("sp_after_pops", sp, 192);
        do_pop;

        // One entry on the stack, ls grant clears last_stk, then three-way contention
        do_push(32'hAAA);
        do_store(32'h10, 32'h55);
        exp_q.push_back(model_stk.pop_back());
        exp_q.push_back(32'h55);
        pop_req = 1'b1;
        push_req = 1'b1; push_data = 32'hBBB;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h10;
        pop_c = -1; ls_c = -1; push_c = -1; nacks = 0;
        for (int c = 1; c <= 14; c++) begin
            tick;
            nacks += int'(stk_ack) + int'(ls_ack);
            if (stk_ack && pop_req) begin
                pop_c = c; pop_req = 1'b0;
                check("arb_pop_data", pop_data, exp_q.pop_front());
            end else if (stk_ack && push_req) begin
                push_c = c; push_req = 1'b0;
            end
            if (ls_ack && ls_req) begin
                ls_c = c; ls_req = 1'b0;
                check("arb_ls_rdata", ls_rdata, exp_q.pop_front());
            end
        end
        pop_req = 1'b0; push_req = 1'b0; ls_req = 1'b0;
        model_stk.push_back(32'hBBB);
        check("arb_pop_cycle", 64'(pop_c), 3);
        check("arb_ls_cycle", 64'(ls_c), 7);
        check("arb_push_cycle", 64'(push_c), 9);
        check("arb_ack_count", 64'(nacks), 3);
        check("arb_sp", sp, 193);

        // Fill the stack, then overflow
        apply_reset;
        for (int i = 0; i < 16; i++) do_push(32'h1000 + 32'(i));
        check("sp_full", sp, 208);
        do_push(32'h9999);
        check("sp_after_ovf", sp, 208);

        // Reset during a pop's WAIT cycle
        pop_req = 1'b1;
        tick;
        pop_req = 1'b0;
        check("rstpop_mem_en", mem_en, 1);
        tick;
        reset = 1'b1;
        tick;
        check("rstpop_no_ack", stk_ack, 0);
        check("rstpop_sp", sp, 192);
        check("rstpop_idle", busy, 0);
        reset = 1'b0;
        model_stk.delete();
        tick;
        check("rstpop_no_late_ack", stk_ack, 0);
        check("rstpop_still_idle", busy, 0);

        // Load with MEM_LAT=3
        exp_q.push_back(32'h0000_DEAD);
        ls_req3 = 1'b1; ls_we3 = 1'b0; ls_addr3 = 32'h40;
        tick;
        ls_req3 = 1'b0;
        check("ld3_mem_en", mem_en3, 1);
        check("ld3_mem_we", mem_we3, 0);
        check("ld3_mem_addr", mem_addr3, 32'h40);
        check("ld3_ack_c1", ls_ack3, 0);
        for (int c = 2; c <= 4; c++) begin
            tick;
            check("ld3_ack_early", ls_ack3, 0);
        end
        tick;
        check("ld3_ack", ls_ack3, 1);
        check("ld3_rdata", ls_rdata3, exp_q.pop_front());
        tick;
        check("ld3_ack_low", ls_ack3, 0);
        check("ld3_idle", busy3, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
